// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
//   rsp_owner_t : which requester receives the read data returned next cycle
//   STARVE_LIMIT_DEF / CNT_W_DEF : default starvation threshold and counter width
//   store_wea() : byte write enables presented to the RAM for a granted store
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_INST = 2'd1,
        RSP_DATA = 2'd2
    } rsp_owner_t;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int CNT_W_DEF        = 3;

    function automatic logic [3:0] store_wea(input logic       gnt,
                                             input logic       we,
                                             input logic [3:0] wea);
        return (gnt && we) ? wea : 4'b0000;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of consecutive cycles in which fetch was denied.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   inc        : fetch requested but not granted this cycle
//   clr        : fetch granted or not requesting this cycle
//   at_limit   : count has reached LIMIT; fetch must win the next contention
module starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt;

    // Saturates rather than wraps so a long stall can never look like a fresh start.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt >= LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the fetch port (i_*) and
// the load/store port (d_*). Data has priority; after STARVE_LIMIT denied
// fetch cycles fetch wins one contention. Read data returns one cycle after
// the grant and is steered by the registered response owner.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   i_req/i_addr         : fetch request;  i_gnt, i_stall, i_rvalid, i_rdata
//   d_req/d_we/d_wea/
//   d_addr/d_wdata       : load/store request; d_gnt, d_stall, d_rvalid, d_rdata
//   m_*                  : RAM port (m_rdata valid the cycle after a read)
//
// Response owner state:
//   state    | meaning
//   RSP_NONE | no read data due this cycle
//   RSP_INST | m_rdata belongs to the fetch port
//   RSP_DATA | m_rdata belongs to the load port
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    output logic              i_stall,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_wea,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_stall,

    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wea,
    output logic              m_en,
    input  logic [31:0]       m_rdata
);

    logic       fetch_due;
    logic       fetch_denied;
    rsp_owner_t rsp_owner;
    rsp_owner_t rsp_next;

    assign fetch_denied = i_req & ~i_gnt;

    starve_counter #(
        .CNT_W (CNT_W),
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (fetch_denied),
        .clr      (~fetch_denied),
        .at_limit (fetch_due)
    );

    // Fetch overrides data only when both contend and fetch has starved long enough.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!reset) begin
            if (d_req && !(i_req && fetch_due)) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    assign i_stall = i_req & ~i_gnt;
    assign d_stall = d_req & ~d_gnt;

    assign m_en    = i_gnt | d_gnt;
    assign m_addr  = d_gnt ? d_addr : i_addr;
    assign m_wea   = store_wea(d_gnt, d_we, d_wea);
    assign m_wdata = d_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_owner <= RSP_NONE;
        end else begin
            rsp_owner <= rsp_next;
        end
    end

    // Stores complete in their grant cycle, so they leave no response owed.
    always_comb begin
        rsp_next = RSP_NONE;
        if (i_gnt) begin
            rsp_next = RSP_INST;
        end else if (d_gnt && !d_we) begin
            rsp_next = RSP_DATA;
        end
    end

    assign i_rvalid = (rsp_owner == RSP_INST);
    assign d_rvalid = (rsp_owner == RSP_DATA);
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

endmodule
